// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: registers ALU results with their control bits, resolves
// branch/jump targets into a one-cycle redirect, and buffers up to two instructions.
module ex_mem_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_alu_o,
    input  logic            in_zero_flag,
    input  logic [RD_W-1:0] in_rd,
    input  logic [4:0]      in_ctrl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic [RD_W-1:0] out_rd,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            misalign_trap
);

    localparam int PW = 2 * XLEN + RD_W + 3;

    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            mem_read;
    logic            mem_write;
    logic            taken;
    logic            misaligned;
    logic [XLEN-1:0] target_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] new_result;
    logic            new_reg_write;
    logic [PW-1:0]   new_payload;

    logic            accept;
    logic            pop;
    logic            main_valid;
    logic            skid_valid;
    logic            ready_q;
    logic [PW-1:0]   main_payload;
    logic [PW-1:0]   skid_payload;

    logic            main_valid_nxt;
    logic            skid_valid_nxt;
    logic            load_main_new;
    logic            load_main_skid;
    logic            load_skid;

    assign is_branch = in_ctrl[4];
    assign is_jal    = in_ctrl[3];
    assign is_jalr   = in_ctrl[2];
    assign mem_read  = in_ctrl[1];
    assign mem_write = in_ctrl[0];

    assign taken      = is_jal | is_jalr | (is_branch & in_zero_flag);
    assign target_sum = is_jalr ? (in_rs1 + in_imm) : (in_pc + in_imm);
    assign target     = is_jalr ? {target_sum[XLEN-1:1], 1'b0} : target_sum;
    assign misaligned = taken & target[1];

    // Misaligned jumps still flow down the pipe, but must not touch state.
    assign new_result    = (is_jal | is_jalr) ? (in_pc + XLEN'(4)) : in_alu_o;
    assign new_reg_write = (in_rd != '0) & ~mem_write & ~is_branch;
    assign new_payload   = {new_result, in_rs2, in_rd,
                            new_reg_write & ~misaligned,
                            mem_read & ~misaligned,
                            mem_write & ~misaligned};

    assign in_ready  = ready_q;
    assign out_valid = main_valid;
    assign accept    = in_valid & ready_q & ~flush;
    assign pop       = main_valid & out_ready;

    assign {out_result, out_store_data, out_rd,
            out_reg_write, out_mem_read, out_mem_write} = main_payload;

    // Buffer steering; accept with a full skid is impossible since ready_q is low then.
    always_comb begin
        main_valid_nxt = main_valid;
        skid_valid_nxt = skid_valid;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            main_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
        end else if (pop && skid_valid) begin
            load_main_skid = 1'b1;
            main_valid_nxt = 1'b1;
            skid_valid_nxt = 1'b0;
        end else if (accept && (!main_valid || pop)) begin
            load_main_new  = 1'b1;
            main_valid_nxt = 1'b1;
        end else if (accept) begin
            load_skid      = 1'b1;
            skid_valid_nxt = 1'b1;
        end else if (pop) begin
            main_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid   <= 1'b0;
            skid_valid   <= 1'b0;
            ready_q      <= 1'b1;
            main_payload <= '0;
            skid_payload <= '0;
        end else begin
            main_valid <= main_valid_nxt;
            skid_valid <= skid_valid_nxt;
            ready_q    <= ~skid_valid_nxt;
            if (load_main_new) begin
                main_payload <= new_payload;
            end else if (load_main_skid) begin
                main_payload <= skid_payload;
            end
            if (load_skid) begin
                skid_payload <= new_payload;
            end
        end
    end

    // Redirect/trap pulses last one cycle; redirect_pc keeps the last good target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            misalign_trap  <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= accept & taken & ~misaligned;
            misalign_trap  <= accept & misaligned;
            if (accept && taken && !misaligned) begin
                redirect_pc <= target;
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed vector table, hand-written stall/flush/reset
// sequences and a randomized run, all scored against a queue-based model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc, in_imm, in_rs1, in_rs2, in_alu_o;
    logic        in_zero_flag;
    logic [4:0]  in_rd;
    logic [4:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result, out_store_data;
    logic [4:0]  out_rd;
    logic        out_reg_write, out_mem_read, out_mem_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_trap;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc, imm, rs1, rs2, alu;
        logic        zf;
        logic [4:0]  rd;
        logic [4:0]  ctrl;
    } inp_t;

    typedef struct {
        inp_t        i;
        logic [31:0] e_result, e_store;
        logic [4:0]  e_rd;
        logic        e_rw, e_mr, e_mw, e_redir, e_trap;
        logic [31:0] e_rpc;
    } vec_t;

    typedef struct {
        logic [31:0] result, store;
        logic [4:0]  rd;
        logic        rw, mr, mw;
    } ent_t;

    ent_t        q[$];
    logic        m_redir = 1'b0;
    logic        m_trap = 1'b0;
    logic [31:0] m_rpc = 32'h0;

    ex_mem_stage #(.XLEN(32), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_alu_o(in_alu_o), .in_zero_flag(in_zero_flag), .in_rd(in_rd), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .misalign_trap(misalign_trap)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input inp_t s, input logic v);
        in_valid     = v;
        in_pc        = s.pc;
        in_imm       = s.imm;
        in_rs1       = s.rs1;
        in_rs2       = s.rs2;
        in_alu_o     = s.alu;
        in_zero_flag = s.zf;
        in_rd        = s.rd;
        in_ctrl      = s.ctrl;
    endtask

    // Reference behaviour: a two-deep FIFO plus arithmetic on the instruction fields.
    task automatic modelUpdate();
        bit          acc;
        bit          pp;
        bit          tk;
        logic [31:0] tgt;
        ent_t        e;
        acc = in_valid && (q.size() < 2) && !flush;
        pp  = (q.size() > 0) && out_ready;
        if (flush) begin
            q.delete();
            m_redir = 1'b0;
            m_trap  = 1'b0;
        end else begin
            if (pp) void'(q.pop_front());
            m_redir = 1'b0;
            m_trap  = 1'b0;
            if (acc) begin
                tk  = in_ctrl[3] || in_ctrl[2] || (in_ctrl[4] && in_zero_flag);
                tgt = in_ctrl[2] ? ((in_rs1 + in_imm) & 32'hFFFF_FFFE) : (in_pc + in_imm);
                e.result = (in_ctrl[3] || in_ctrl[2]) ? in_pc + 32'd4 : in_alu_o;
                e.store  = in_rs2;
                e.rd     = in_rd;
                e.rw     = (in_rd != 0) && !in_ctrl[0] && !in_ctrl[4];
                e.mr     = in_ctrl[1];
                e.mw     = in_ctrl[0];
                if (tk && (tgt % 4 >= 2)) begin
                    m_trap = 1'b1;
                    e.rw = 1'b0;
                    e.mr = 1'b0;
                    e.mw = 1'b0;
                end else if (tk) begin
                    m_redir = 1'b1;
                    m_rpc   = tgt;
                end
                q.push_back(e);
            end
        end
    endtask

    task automatic compareModel();
        checkOutput("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
        checkOutput("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
        checkOutput("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_redir});
        checkOutput("misalign_trap", {31'b0, misalign_trap}, {31'b0, m_trap});
        checkOutput("redirect_pc", redirect_pc, m_rpc);
        if (q.size() > 0) begin
            checkOutput("out_result", out_result, q[0].result);
            checkOutput("out_store_data", out_store_data, q[0].store);
            checkOutput("out_rd", {27'b0, out_rd}, {27'b0, q[0].rd});
            checkOutput("out_ctrl", {29'b0, out_reg_write, out_mem_read, out_mem_write},
                        {29'b0, q[0].rw, q[0].mr, q[0].mw});
        end
    endtask

    task automatic stepCycle();
        modelUpdate();
        @(posedge clk);
        #1;
        compareModel();
    endtask

    task automatic checkAllClear(input string tag);
        checkOutput({tag, "_out_valid"}, {31'b0, out_valid}, 32'h0);
        checkOutput({tag, "_in_ready"}, {31'b0, in_ready}, 32'h1);
        checkOutput({tag, "_redirect"}, {30'b0, redirect_valid, misalign_trap}, 32'h0);
        checkOutput({tag, "_redirect_pc"}, redirect_pc, 32'h0);
        checkOutput({tag, "_out_data"}, out_result | out_store_data | {27'b0, out_rd}, 32'h0);
        checkOutput({tag, "_out_ctrl"}, {29'b0, out_reg_write, out_mem_read, out_mem_write}, 32'h0);
    endtask

    function automatic inp_t mkInp(input logic [31:0] pc, imm, rs1, rs2, alu,
                                   input logic zf, input logic [4:0] rd, ctrl);
        inp_t s;
        s.pc = pc; s.imm = imm; s.rs1 = rs1; s.rs2 = rs2; s.alu = alu;
        s.zf = zf; s.rd = rd; s.ctrl = ctrl;
        return s;
    endfunction

    function automatic inp_t randInp();
        return mkInp($urandom, $urandom, $urandom, $urandom, $urandom,
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    endfunction

    vec_t vecs[14];
    inp_t idle_in;
    inp_t a_in, b_in, c_in, jal_in;

    initial begin
        // ctrl = {is_branch, is_jal, is_jalr, mem_read, mem_write}
        vecs[0]  = '{mkInp(32'h0, 32'h0, 32'h0, 32'h11, 32'h15, 1'b0, 5'd3, 5'b00000),
                     32'h15, 32'h11, 5'd3, 1, 0, 0, 0, 0, 32'h0};
        vecs[1]  = '{mkInp(32'h100, 32'hFFFF_FFF0, 32'h0, 32'h0, 32'h1, 1'b1, 5'd0, 5'b10000),
                     32'h1, 32'h0, 5'd0, 0, 0, 0, 1, 0, 32'hF0};
        vecs[2]  = '{mkInp(32'h100, 32'h40, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'b10000),
                     32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 32'h0};
        vecs[3]  = '{mkInp(32'h200, 32'h1, 32'h1003, 32'h0, 32'h55, 1'b0, 5'd1, 5'b00100),
                     32'h204, 32'h0, 5'd1, 1, 0, 0, 1, 0, 32'h1004};
        vecs[4]  = '{mkInp(32'h200, 32'h9, 32'h1000, 32'h0, 32'h55, 1'b0, 5'd2, 5'b00100),
                     32'h204, 32'h0, 5'd2, 1, 0, 0, 1, 0, 32'h1008};
        vecs[5]  = '{mkInp(32'h200, 32'h4, 32'h1003, 32'h0, 32'h55, 1'b0, 5'd1, 5'b00100),
                     32'h204, 32'h0, 5'd1, 0, 0, 0, 0, 1, 32'h0};
        vecs[6]  = '{mkInp(32'h200, 32'h1, 32'h1001, 32'h0, 32'h55, 1'b0, 5'd1, 5'b00100),
                     32'h204, 32'h0, 5'd1, 0, 0, 0, 0, 1, 32'h0};
        vecs[7]  = '{mkInp(32'h300, 32'h40, 32'h0, 32'h0, 32'h0, 1'b0, 5'd1, 5'b01000),
                     32'h304, 32'h0, 5'd1, 1, 0, 0, 1, 0, 32'h340};
        vecs[8]  = '{mkInp(32'h300, 32'h2, 32'h0, 32'h0, 32'h0, 1'b0, 5'd1, 5'b01000),
                     32'h304, 32'h0, 5'd1, 0, 0, 0, 0, 1, 32'h0};
        vecs[9]  = '{mkInp(32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0, 32'h0, 1'b0, 5'd4, 5'b01000),
                     32'h0, 32'h0, 5'd4, 1, 0, 0, 1, 0, 32'h4};
        vecs[10] = '{mkInp(32'h400, 32'h0, 32'h0, 32'h0, 32'h2000, 1'b0, 5'd7, 5'b00010),
                     32'h2000, 32'h0, 5'd7, 1, 1, 0, 0, 0, 32'h0};
        vecs[11] = '{mkInp(32'h404, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h2004, 1'b0, 5'd0, 5'b00001),
                     32'h2004, 32'hDEAD_BEEF, 5'd0, 0, 0, 1, 0, 0, 32'h0};
        vecs[12] = '{mkInp(32'h408, 32'h0, 32'h0, 32'h0, 32'h99, 1'b0, 5'd0, 5'b00000),
                     32'h99, 32'h0, 5'd0, 0, 0, 0, 0, 0, 32'h0};
        vecs[13] = '{mkInp(32'h40C, 32'h0, 32'h0, 32'h1234, 32'h2008, 1'b0, 5'd5, 5'b00001),
                     32'h2008, 32'h1234, 5'd5, 0, 0, 1, 0, 0, 32'h0};

        idle_in = mkInp(0, 0, 0, 0, 0, 1'b0, 5'd0, 5'd0);
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        applyStimulus(idle_in, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkAllClear("reset");
        rst_n = 1'b1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].i, 1'b1);
            out_ready = 1'b1;
            stepCycle();
            checkOutput($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'h1);
            checkOutput($sformatf("vec%0d_result", i), out_result, vecs[i].e_result);
            checkOutput($sformatf("vec%0d_store", i), out_store_data, vecs[i].e_store);
            checkOutput($sformatf("vec%0d_rd", i), {27'b0, out_rd}, {27'b0, vecs[i].e_rd});
            checkOutput($sformatf("vec%0d_ctrl", i), {29'b0, out_reg_write, out_mem_read, out_mem_write},
                        {29'b0, vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw});
            checkOutput($sformatf("vec%0d_redirect", i), {30'b0, redirect_valid, misalign_trap},
                        {30'b0, vecs[i].e_redir, vecs[i].e_trap});
            if (vecs[i].e_redir)
                checkOutput($sformatf("vec%0d_redirect_pc", i), redirect_pc, vecs[i].e_rpc);
            applyStimulus(idle_in, 1'b0);
            stepCycle();
            checkOutput($sformatf("vec%0d_pulse_end", i), {30'b0, redirect_valid, misalign_trap}, 32'h0);
        end

        $display("[TB] backpressure sequence");
        a_in = mkInp(32'h500, 0, 0, 32'hA, 32'hAAAA, 1'b0, 5'd10, 5'b00000);
        b_in = mkInp(32'h504, 0, 0, 32'hB, 32'hBBBB, 1'b0, 5'd11, 5'b00000);
        c_in = mkInp(32'h508, 0, 0, 32'hC, 32'hCCCC, 1'b0, 5'd12, 5'b00000);
        out_ready = 1'b0;
        applyStimulus(a_in, 1'b1);
        stepCycle();
        applyStimulus(b_in, 1'b1);
        stepCycle();
        checkOutput("bp_in_ready_full", {31'b0, in_ready}, 32'h0);
        applyStimulus(c_in, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput("bp_stall_result", out_result, 32'hAAAA);
        checkOutput("bp_stall_rd", {27'b0, out_rd}, 32'd10);
        out_ready = 1'b1;
        stepCycle();
        checkOutput("bp_second_B", out_result, 32'hBBBB);
        stepCycle();
        checkOutput("bp_third_C", out_result, 32'hCCCC);
        applyStimulus(idle_in, 1'b0);
        stepCycle();
        checkOutput("bp_drained", {31'b0, out_valid}, 32'h0);

        $display("[TB] flush sequences");
        jal_in = mkInp(32'h600, 32'h20, 0, 0, 0, 1'b0, 5'd1, 5'b01000);
        out_ready = 1'b0;
        applyStimulus(a_in, 1'b1);
        stepCycle();
        applyStimulus(b_in, 1'b1);
        stepCycle();
        applyStimulus(jal_in, 1'b1);
        flush = 1'b1;
        stepCycle();
        flush = 1'b0;
        checkOutput("flush_full_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("flush_full_ready", {31'b0, in_ready}, 32'h1);
        checkOutput("flush_full_redirect", {30'b0, redirect_valid, misalign_trap}, 32'h0);
        applyStimulus(jal_in, 1'b1);
        flush = 1'b1;
        stepCycle();
        flush = 1'b0;
        checkOutput("flush_accept_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("flush_accept_redirect", {31'b0, redirect_valid}, 32'h0);
        applyStimulus(idle_in, 1'b0);
        out_ready = 1'b1;
        stepCycle();

        $display("[TB] asynchronous reset mid-stall");
        out_ready = 1'b0;
        applyStimulus(a_in, 1'b1);
        stepCycle();
        applyStimulus(jal_in, 1'b1);
        stepCycle();
        checkOutput("rst_pre_redirect", {31'b0, redirect_valid}, 32'h1);
        applyStimulus(idle_in, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllClear("async_reset");
        q.delete();
        m_redir = 1'b0;
        m_trap = 1'b0;
        m_rpc = 32'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stepCycle();
        checkOutput("rst_release_ready", {31'b0, in_ready}, 32'h1);

        $display("[TB] randomized run");
        for (int n = 0; n < 600; n++) begin
            applyStimulus(randInp(), $urandom_range(0, 9) < 7);
            out_ready = $urandom_range(0, 9) < 6;
            flush = $urandom_range(0, 99) < 3;
            stepCycle();
        end
        flush = 1'b0;
        applyStimulus(idle_in, 1'b0);
        out_ready = 1'b1;
        stepCycle();
        stepCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
